// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a synchronous flush that overrides all other requests.
// The read port is either first-word fall-through or a registered output with one cycle
// of latency, chosen by FALLTHROUGH.
//
// Ports:
//   clk           - clock, rising edge
//   rst_n         - asynchronous active-low reset
//   flush         - synchronous clear of pointers and error flags
//   winc, wdata   - write request and data
//   wfull         - FIFO holds DEPTH words
//   walmost_full  - count >= AFULL_THRESH
//   rinc          - read (pop) request
//   rdata         - read data (head of queue, or registered pop result)
//   rempty        - FIFO holds no words
//   ralmost_empty - count <= AEMPTY_THRESH
//   count         - current occupancy, 0..DEPTH
//   overflow      - sticky: write requested while full
//   underflow     - sticky: read requested while empty
module sync_fifo #(
  parameter int unsigned DATASIZE      = 8,
  parameter int unsigned ADDRSIZE      = 4,
  parameter string       FALLTHROUGH   = "TRUE",
  parameter int unsigned AFULL_THRESH  = (1 << ADDRSIZE) - 1,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  output logic                wfull,
  output logic                walmost_full,
  input  logic                rinc,
  output logic [DATASIZE-1:0] rdata,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned Depth = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DepthW   = (ADDRSIZE + 1)'(Depth);
  localparam logic [ADDRSIZE:0] AFullW   = (ADDRSIZE + 1)'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AEmptyW  = (ADDRSIZE + 1)'(AEMPTY_THRESH);

  logic [DATASIZE-1:0] r_mem [Depth];
  logic [ADDRSIZE:0]   r_wptr, r_rptr;
  logic                r_overflow, r_underflow;

  logic [ADDRSIZE:0]   w_count;
  logic                w_full, w_empty;
  logic                w_wr_en, w_rd_en;

  // Pointers carry an extra wrap bit, so modular subtraction yields 0..Depth directly.
  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == DepthW);
  assign w_empty = (w_count == '0);

  // Acceptance looks only at registered state: a pop in the same cycle never frees a slot
  // for a write to a full FIFO, and a push never feeds a pop from an empty one.
  assign w_wr_en = winc && !w_full  && !flush;
  assign w_rd_en = rinc && !w_empty && !flush;

  // Storage is deliberately not reset; reads of stale words are masked by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[ADDRSIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (winc && w_full)  r_overflow  <= 1'b1;
      if (rinc && w_empty) r_underflow <= 1'b1;
    end
  end

  if (FALLTHROUGH == "TRUE") begin : g_fallthrough
    // Head of queue straight from storage; meaningless while empty.
    assign rdata = r_mem[r_rptr[ADDRSIZE-1:0]];
  end else begin : g_registered
    logic [DATASIZE-1:0] r_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rdata <= '0;
      end else if (w_rd_en) begin
        r_rdata <= r_mem[r_rptr[ADDRSIZE-1:0]];
      end
    end
    assign rdata = r_rdata;
  end

  assign count         = w_count;
  assign wfull         = w_full;
  assign rempty        = w_empty;
  assign walmost_full  = (w_count >= AFullW);
  assign ralmost_empty = (w_count <= AEmptyW);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule
